// File: rtl/decision_stream_arbiter.sv
// decision_stream_arbiter: frame-granular 2:1 Avalon-ST arbiter with MM control and statistics
//   clk, reset        : single clock, synchronous active-high reset
//   s_*               : Avalon-MM slave (CTRL, STATUS, FRAMES0, FRAMES1, DROPS)
//   sink0_*, sink1_*  : requesting video streams
//   source_*          : granted stream towards the decision block
//   mode              : currently or last granted channel
module decision_stream_arbiter #(
  parameter int DATA_W = 24,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_chipselect,
  input  logic              s_read,
  input  logic              s_write,
  input  logic [2:0]        s_address,
  input  logic [31:0]       s_writedata,
  output logic [31:0]       s_readdata,
  input  logic [DATA_W-1:0] sink0_data,
  input  logic              sink0_valid,
  input  logic              sink0_sop,
  input  logic              sink0_eop,
  output logic              sink0_ready,
  input  logic [DATA_W-1:0] sink1_data,
  input  logic              sink1_valid,
  input  logic              sink1_sop,
  input  logic              sink1_eop,
  output logic              sink1_ready,
  output logic [DATA_W-1:0] source_data,
  output logic              source_valid,
  output logic              source_sop,
  output logic              source_eop,
  input  logic              source_ready,
  output logic              mode
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;
  logic [1:0] state, state_nxt, policy;
  logic enable, last, idle, g0, g1, req0, req1, pick, eop_acc, drop0, drop1, clr, wr, rd;
  logic [CNT_W-1:0] frames0, frames1, drops;
  logic [31:0] rd_mux;
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W+1)'(n);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction
  always_comb begin
    idle = state == IDLE;
    g0 = state == GRANT0;
    g1 = state == GRANT1;
    req0 = enable & sink0_valid & sink0_sop;
    req1 = enable & sink1_valid & sink1_sop;
    // with both requesting: policy 1/2 fix the winner, 0 and 3 alternate away from last
    pick = (req0 & req1) ? (policy == 2'd1 ? 1'b0 : policy == 2'd2 ? 1'b1 : ~last) : req1;
    source_valid = g0 ? sink0_valid : g1 ? sink1_valid : 1'b0;
    source_sop = g0 ? sink0_sop : g1 ? sink1_sop : 1'b0;
    source_eop = g0 ? sink0_eop : g1 ? sink1_eop : 1'b0;
    source_data = g0 ? sink0_data : g1 ? sink1_data : '0;
    // idle: SOP beats wait for arbitration, stray mid-frame beats are swallowed
    drop0 = idle & sink0_valid & ~sink0_sop;
    drop1 = idle & sink1_valid & ~sink1_sop;
    sink0_ready = g0 ? source_ready : drop0;
    sink1_ready = g1 ? source_ready : drop1;
    eop_acc = source_valid & source_ready & source_eop;
    state_nxt = idle ? ((req0 | req1) ? (pick ? GRANT1 : GRANT0) : IDLE) :
                ((g0 | g1) & ~eop_acc) ? state : IDLE;
    wr = s_chipselect & s_write;
    rd = s_chipselect & s_read;
    clr = wr & (s_address == 3'd4);
    case (s_address)
      3'd0: rd_mux = {29'd0, policy, enable};
      3'd1: rd_mux = {29'd0, last, state};
      3'd2: rd_mux = 32'(frames0);
      3'd3: rd_mux = 32'(frames1);
      3'd4: rd_mux = 32'(drops);
      default: rd_mux = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last <= 1'b1;
      mode <= 1'b0;
      enable <= 1'b1;
      policy <= 2'd0;
      frames0 <= '0;
      frames1 <= '0;
      drops <= '0;
      s_readdata <= '0;
    end else begin
      state <= state_nxt;
      if (idle & (req0 | req1)) begin
        last <= pick;
        mode <= pick;
      end
      if (wr & (s_address == 3'd0)) {policy, enable} <= s_writedata[2:0];
      frames0 <= clr ? '0 : sat_add(frames0, {1'b0, g0 & eop_acc});
      frames1 <= clr ? '0 : sat_add(frames1, {1'b0, g1 & eop_acc});
      drops <= clr ? '0 : sat_add(drops, {1'b0, drop0} + {1'b0, drop1});
      if (rd) s_readdata <= rd_mux;
    end
  end
endmodule

// File: doc/decision_stream_arbiter.md
# decision_stream_arbiter

Frame-granular 2:1 arbiter that shares the single pixel-decision datapath between two 24-bit Avalon-ST video sources (e.g. camera pipeline and test-pattern/replay path). It grants the downstream stream to one requester for a whole frame (SOP to EOP) and switches only at frame boundaries, so the decision block never sees interleaved pixels. It exports the granted channel on a `mode` conduit so the downstream block knows which source it is processing. Policy, enable and per-channel statistics are exposed on a small Avalon-MM slave.

## Interface
Parameters:
- `DATA_W`, 24: pixel beat width.
- `CNT_W`, 32: statistics counter width.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `s_chipselect`, `s_read`, `s_write` in 1: MM slave strobes.
- `s_address` in 3: register index.
- `s_writedata` in 32: write data.
- `s_readdata` out 32: registered read data.
- `sink0_data` in DATA_W: channel 0 beat.
- `sink0_valid`, `sink0_sop`, `sink0_eop` in 1: channel 0 qualifiers.
- `sink0_ready` out 1: channel 0 backpressure.
- `sink1_*`: same set of ports for channel 1.
- `source_data` out DATA_W, `source_valid`/`source_sop`/`source_eop` out 1: stream to the decision block.
- `source_ready` in 1: downstream backpressure.
- `mode` out 1: conduit giving the currently or last granted channel.

## Operation
- FSM states: IDLE, GRANT0, GRANT1. Reset puts the FSM in IDLE.
- **IDLE**
  - A channel requests when `valid & sop`. Any request requires CTRL.enable=1.
  - Policy 0 (round-robin): grant the requesting channel other than `last`. If only one requests, grant it.
  - Policy 1: channel 0 has fixed priority. Policy 2: channel 1 has fixed priority. Policy 3 is treated as 0.
  - On grant: go to GRANTn, set `last`=n and `mode`=n.
  - The SOP beat is not consumed in IDLE: `sinkN_ready`=0 for SOP beats.
  - Non-SOP beats with valid=1 are discarded: `sinkN_ready`=1 and the drop counter increments. This happens regardless of enable.
- **GRANTn**
  - Combinational pass-through: `source_*` = `sinkn_*` and `sinkn_ready` = `source_ready`.
  - The other channel's ready is 0, so it is held, not dropped.
  - On an accepted beat with eop (`valid & ready & eop`): increment `frames[n]` and go to IDLE.
  - A single-beat frame (sop & eop) returns to IDLE after its one accepted beat.
  - Clearing enable mid-frame does not abort; the frame completes.
  - A repeated SOP inside a granted frame is passed through unchanged.
- In IDLE, `source_valid` is 0.
- Registers (reads return 0 in unused bits):
  - 0 CTRL, R/W: bit0 enable (reset 1), bits2:1 policy (reset 0).
  - 1 STATUS, RO: bits1:0 state (0 IDLE, 1 GRANT0, 2 GRANT1), bit2 `last`.
  - 2 FRAMES0, RO.
  - 3 FRAMES1, RO.
  - 4 DROPS, RO; a write of any value clears FRAMES0, FRAMES1 and DROPS.
  - 5–7: read 0, writes ignored.
- Counters saturate at all-ones. If a clear and an increment occur in the same cycle, the clear wins and the counter is 0.

## Timing
- Reset values:
  - FSM IDLE, `last`=1 (so channel 0 wins the first round-robin), `mode`=0.
  - Counters 0, `s_readdata`=0.
  - `source_valid`=0; `sinkN_ready`=0 unless a non-SOP beat is present.
- Arbitration costs exactly one bubble cycle per frame: the SOP is seen in IDLE in cycle t and transferred in GRANT in cycle t+1 (if `source_ready`=1).
- Zero-latency data path while granted; there is no internal buffering.
- Back-to-back frames: the EOP is accepted in cycle t, the FSM is IDLE in t+1 (arbitrates), and the next SOP transfers in t+2.
- MM read latency is 1: `s_readdata` is updated at the edge where `s_chipselect & s_read`, and holds otherwise.
- MM writes take effect at the edge they are sampled. A policy change affects the next arbitration only.
- `mode` changes only at the edge that enters GRANTn.
- Reset asserted mid-frame returns the FSM to IDLE on the next edge and drops the remainder of the frame. Non-SOP beats that follow are discarded and counted after reset deasserts.

## Test plan
- Enable=1, policy 0; both channels continuously offer 4-beat frames; `source_ready`=1 → granted order 0,1,0,1; `mode` toggles accordingly; FRAMES0=FRAMES1=2 after 4 frames; one bubble before each SOP on the source.
- Policy 1; both request continuously → only channel 0 frames appear; channel 1 `sink1_ready` stays 0 and its SOP is held; FRAMES1=0.
- Channel 0 sends 3 non-SOP beats while IDLE, then a 2-beat frame → 3 beats are accepted and discarded, DROPS=3, the frame is forwarded intact.
- Granted 5-beat frame with `source_ready` low every other cycle → source beats match the sink exactly, the EOP lands in the correct cycle, the FSM returns to IDLE only after the EOP handshake.
- Enable cleared at beat 2 of a 4-beat frame → the frame completes; a subsequent SOP is not granted; STATUS reads 0; after re-enable the next frame is granted.
- Write to address 4 in the same cycle as an EOP acceptance → FRAMESn reads 0 (clear wins); a read of address 1 shows `s_readdata` valid one cycle after the read strobe.
